lpddr2_avm_master: RTL and testbench
====================================

Name: lpddr2_avm_master

Overview:
- Avalon-MM initiator that drives the single avm_* command port of the LPDDR2 controller wrapper.
- Converts a simple one-word request/response interface on the system side into single-beat Avalon-MM reads and writes.
- Handles waitrequest back-pressure, burstbegin generation, read-data return, and a read-response timeout.
- Sits between the system bus adapter and the controller, entirely in the avm_clk domain.

Parameters:
- ADDR_W, 27, width of avm_addr in 32-bit word units.
- TIMEOUT, 1024, maximum cycles to wait for avm_rdata_valid after a read is accepted; legal range 2..65535.

Ports:
- avm_clk  in  1  single clock for all logic.
- avm_rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  system request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address; bits [1:0] ignored; word address = req_addr[ADDR_W+1:2].
- req_wdata  in  32  write data.
- req_be  in  4  byte enables.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  read data; valid when resp_valid is high.
- resp_err  out  1  1 = read timed out; qualified by resp_valid.
- avm_ready  in  1  controller waitrequest_n.
- avm_burstbegin  out  1  first cycle of each command.
- avm_addr  out  ADDR_W  word address.
- avm_rdata_valid  in  1  read data strobe.
- avm_rdata  in  32  read data.
- avm_wdata  out  32  write data.
- avm_be  out  4  byte enables.
- avm_read_req  out  1  read command.
- avm_write_req  out  1  write command.
- avm_size  out  1  burst count; constant 1.

Behaviour:
- Reset values:
  - All outputs are 0 except avm_size = 1.
  - FSM is in IDLE; the timeout counter and the stale flag are cleared.
  - Reset is asynchronous and takes effect mid-transaction: commands drop immediately, and no resp_valid is produced for the aborted request.
- req_ready is registered. It rises on the first edge after reset release and is high only while the FSM is in IDLE.
- FSM states: IDLE, CMD, RWAIT, RESP.
- IDLE:
  - On req_valid & req_ready at edge N, latch addr/wdata/be/write and go to CMD.
  - From cycle N+1: avm_write_req or avm_read_req = 1, avm_burstbegin = 1, and req_ready = 0.
- CMD:
  - The command and all address, data and byte-enable outputs are held stable until avm_ready is sampled high.
  - avm_burstbegin is high only in the first cycle of CMD, even under back-pressure.
  - CMD has no timeout, so it waits indefinitely during controller calibration.
  - On acceptance of a write: drop the command and go to RESP.
  - On acceptance of a read: drop the command, clear the counter, and go to RWAIT.
- RWAIT:
  - The counter increments every cycle.
  - On avm_rdata_valid: capture avm_rdata into resp_rdata, set resp_err = 0, and go to RESP.
  - If the counter reaches TIMEOUT-1 without data: set resp_err = 1, set resp_rdata = 0, set the stale flag, and go to RESP.
  - If data and the timeout occur in the same cycle, data wins.
- RESP: resp_valid = 1 for exactly one cycle, then go to IDLE. resp_rdata and resp_err hold until the next response.
- Write latency: resp_valid is high in the cycle after the cycle in which avm_ready was sampled high.
- Read latency: resp_valid is high in the cycle after avm_rdata_valid.
- Stale data handling:
  - An avm_rdata_valid that arrives while the stale flag is set, and outside RWAIT, is discarded and clears the flag.
  - An avm_rdata_valid in RWAIT with the stale flag set is also discarded and clears the flag. It does not complete the current read, and the counter keeps running.
  - An avm_rdata_valid with no read outstanding and no stale flag is ignored.
- avm_wdata and avm_be keep their last latched values outside CMD. avm_read_req and avm_write_req are never high together.

Test Plan:
- Write with no back-pressure.
  - Stimulus: write req_addr = 0x0000_0100, wdata = 0xCAFE_F00D, be = 0xF, with avm_ready held high.
  - Response: one cycle with avm_write_req = 1, avm_burstbegin = 1, avm_addr = 0x40.
  - Then resp_valid pulses once with resp_err = 0, and req_ready returns high on the following cycle.
- Read under back-pressure.
  - Stimulus: read addr = 0x0000_0010 with avm_ready low for 5 cycles; avm_rdata_valid arrives with 0x1234_5678 three cycles after acceptance.
  - Response: avm_read_req is held for 6 cycles with avm_addr = 0x4 throughout; avm_burstbegin is high only in the first cycle.
  - Then resp_valid pulses with resp_rdata = 0x1234_5678 and resp_err = 0.
- Read timeout and stale data.
  - Stimulus: with TIMEOUT = 8, issue a read and withhold avm_rdata_valid.
  - Response: resp_valid pulses with resp_err = 1 and resp_rdata = 0.
  - Then issue a second read: the late rdata_valid carrying 0xAAAA_AAAA is discarded, and the next rdata_valid carrying 0x5555_5555 is returned.
- Simultaneous data and timeout.
  - Stimulus: avm_rdata_valid carrying 0x0BAD_CAFE arrives in the exact cycle the counter hits TIMEOUT-1.
  - Response: resp_err = 0, resp_rdata = 0x0BAD_CAFE, and the stale flag stays clear.
- Reset mid-command.
  - Stimulus: assert avm_rst_n low while in CMD with avm_ready low.
  - Response: avm_write_req drops immediately with no clock edge required, and no resp_valid appears.
  - req_ready goes high one edge after release.
- Back-to-back requests.
  - Stimulus: req_valid held high with three writes queued.
  - Response: each write is accepted only when req_ready is high, and exactly three resp_valid pulses occur.
  - avm_read_req is never asserted, and avm_size = 1 throughout.

Source files
------------

// File: rtl/lpddr2_avm_master.sv
// Avalon-MM initiator for the LPDDR2 controller command port.
// Converts one-word system requests into single-beat reads and writes, and applies a timeout to read data.
module lpddr2_avm_master #(
   parameter int ADDR_W  = 27,
   parameter int TIMEOUT = 1024
) (
   input  logic              avm_clk,
   input  logic              avm_rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_be,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   input  logic              avm_ready,
   output logic              avm_burstbegin,
   output logic [ADDR_W-1:0] avm_addr,
   input  logic              avm_rdata_valid,
   input  logic [31:0]       avm_rdata,
   output logic [31:0]       avm_wdata,
   output logic [3:0]        avm_be,
   output logic              avm_read_req,
   output logic              avm_write_req,
   output logic              avm_size
);

   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CMD   = 2'd1,
      S_RWAIT = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_next;

   logic              r_req_ready;
   logic              r_write;
   logic              r_first;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_be;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_stale;
   logic [31:0]       r_resp_rdata;
   logic              r_resp_err;

   logic              w_accept;
   logic              w_cmd_done;
   logic              w_data_ok;
   logic              w_timeout;
   logic              w_unused_addr;

   assign w_unused_addr = ^{req_addr[1:0], req_addr[31:ADDR_W+2]};

   assign w_accept   = (r_state == S_IDLE) && req_valid && r_req_ready;
   assign w_cmd_done = (r_state == S_CMD) && avm_ready;
   // A strobe seen while the stale flag is set belongs to a read that already timed out.
   assign w_data_ok  = avm_rdata_valid && !r_stale;
   assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1)) && !w_data_ok;

   // State register
   always_ff @(posedge avm_clk or negedge avm_rst_n) begin
      if (!avm_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next = S_CMD;
            end
         end
         S_CMD: begin
            if (avm_ready) begin
               w_state_next = r_write ? S_RESP : S_RWAIT;
            end
         end
         S_RWAIT: begin
            if (w_data_ok || w_timeout) begin
               w_state_next = S_RESP;
            end
         end
         S_RESP: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Output decode
   always_comb begin
      avm_read_req   = 1'b0;
      avm_write_req  = 1'b0;
      avm_burstbegin = 1'b0;
      resp_valid     = 1'b0;
      case (r_state)
         S_CMD: begin
            avm_read_req   = !r_write;
            avm_write_req  = r_write;
            avm_burstbegin = r_first;
         end
         S_RESP: begin
            resp_valid = 1'b1;
         end
         default: begin
            resp_valid = 1'b0;
         end
      endcase
   end

   always_ff @(posedge avm_clk or negedge avm_rst_n) begin
      if (!avm_rst_n) begin
         r_req_ready <= 1'b0;
         r_write     <= 1'b0;
         r_first     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_be        <= '0;
      end else begin
         r_req_ready <= (w_state_next == S_IDLE);
         if (w_accept) begin
            r_write <= req_write;
            r_first <= 1'b1;
            r_addr  <= req_addr[ADDR_W+1:2];
            r_wdata <= req_wdata;
            r_be    <= req_be;
         end else if (r_state == S_CMD) begin
            r_first <= 1'b0;
         end
      end
   end

   // Read timeout counter and stale-data tracking
   always_ff @(posedge avm_clk or negedge avm_rst_n) begin
      if (!avm_rst_n) begin
         r_cnt   <= '0;
         r_stale <= 1'b0;
      end else begin
         if (w_cmd_done && !r_write) begin
            r_cnt <= '0;
         end else if (r_state == S_RWAIT) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end

         if ((r_state == S_RWAIT) && w_timeout) begin
            r_stale <= 1'b1;
         end else if (avm_rdata_valid && r_stale) begin
            r_stale <= 1'b0;
         end
      end
   end

   always_ff @(posedge avm_clk or negedge avm_rst_n) begin
      if (!avm_rst_n) begin
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
      end else begin
         if (w_cmd_done && r_write) begin
            r_resp_err <= 1'b0;
         end else if ((r_state == S_RWAIT) && w_data_ok) begin
            r_resp_rdata <= avm_rdata;
            r_resp_err   <= 1'b0;
         end else if ((r_state == S_RWAIT) && w_timeout) begin
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b1;
         end
      end
   end

   assign req_ready  = r_req_ready;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;
   assign avm_addr   = r_addr;
   assign avm_wdata  = r_wdata;
   assign avm_be     = r_be;
   assign avm_size   = 1'b1;

endmodule

// File: tb/tb_lpddr2_avm_master.sv
// Self-checking bench for lpddr2_avm_master: directed test-plan steps followed by random transactions
// checked against a transaction-level model of response data, error and latency.
module tb_lpddr2_avm_master;

   localparam int ADDR_W = 27;
   localparam int TMO    = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_write = 1'b0;
   logic [31:0]       req_addr = '0;
   logic [31:0]       req_wdata = '0;
   logic [3:0]        req_be = '0;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              avm_ready = 1'b0;
   logic              avm_burstbegin;
   logic [ADDR_W-1:0] avm_addr;
   logic              avm_rdata_valid = 1'b0;
   logic [31:0]       avm_rdata = '0;
   logic [31:0]       avm_wdata;
   logic [3:0]        avm_be;
   logic              avm_read_req;
   logic              avm_write_req;
   logic              avm_size;

   int n_chk  = 0;
   int n_fail = 0;
   bit m_stale = 1'b0;

   lpddr2_avm_master #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
      .avm_clk         (clk),
      .avm_rst_n       (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_write       (req_write),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .req_be          (req_be),
      .resp_valid      (resp_valid),
      .resp_rdata      (resp_rdata),
      .resp_err        (resp_err),
      .avm_ready       (avm_ready),
      .avm_burstbegin  (avm_burstbegin),
      .avm_addr        (avm_addr),
      .avm_rdata_valid (avm_rdata_valid),
      .avm_rdata       (avm_rdata),
      .avm_wdata       (avm_wdata),
      .avm_be          (avm_be),
      .avm_read_req    (avm_read_req),
      .avm_write_req   (avm_write_req),
      .avm_size        (avm_size)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One complete transaction. Read pulses are given as cycle offsets after command
   // acceptance (cycle 0 is the first cycle after avm_ready is sampled high); -1 = none.
   task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int bp,
                          input int p1, input logic [31:0] d1,
                          input int p2, input logic [31:0] d2);
      int          exp_t;
      logic [31:0] exp_rd;
      bit          exp_err;
      bit          done;
      int          got_t;
      int          w;
      int          p;
      logic [31:0] d;

      // Reference: walk the data strobes in time order; the first one is eaten by a pending
      // stale flag, the first unclaimed one completes the read, none left means a timeout.
      exp_t   = TMO;
      exp_rd  = 32'h0;
      exp_err = 1'b1;
      done    = 1'b0;
      if (!wr) begin
         for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? p1 : p2;
            d = (k == 0) ? d1 : d2;
            if (!done && p >= 0 && p <= TMO - 1) begin
               if (m_stale) begin
                  m_stale = 1'b0;
               end else begin
                  done    = 1'b1;
                  exp_t   = p + 1;
                  exp_rd  = d;
                  exp_err = 1'b0;
               end
            end
         end
         if (!done) m_stale = 1'b1;
      end

      w = 0;
      while (req_ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("ready_before_req", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      @(negedge clk);
      req_valid = 1'b0;
      req_wdata = $urandom;
      req_be    = 4'($urandom);
      req_addr  = $urandom;

      for (int c = 0; c <= bp; c++) begin
         chk("cmd_write_req", 32'(avm_write_req), 32'(wr));
         chk("cmd_read_req", 32'(avm_read_req), 32'(!wr));
         chk("cmd_burstbegin", 32'(avm_burstbegin), 32'(c == 0));
         chk("cmd_addr", 32'(avm_addr), 32'(addr[28:2]));
         chk("cmd_req_ready", 32'(req_ready), 32'd0);
         chk("cmd_size", 32'(avm_size), 32'd1);
         if (wr) begin
            chk("cmd_wdata", avm_wdata, wdata);
            chk("cmd_be", 32'(avm_be), 32'(be));
         end
         avm_ready = (c == bp);
         @(negedge clk);
      end
      avm_ready = 1'(($urandom % 2));

      if (wr) begin
         chk("wr_resp_valid", 32'(resp_valid), 32'd1);
         chk("wr_resp_err", 32'(resp_err), 32'd0);
         chk("wr_cmd_dropped", 32'(avm_write_req), 32'd0);
         @(negedge clk);
      end else begin
         got_t = -1;
         chk("rd_cmd_dropped", 32'(avm_read_req), 32'd0);
         for (int t = 0; t < TMO + 4; t++) begin
            if (resp_valid === 1'b1) begin
               got_t = t;
               break;
            end
            avm_rdata_valid = (t == p1) || (t == p2);
            avm_rdata       = (t == p1) ? d1 : ((t == p2) ? d2 : $urandom);
            @(negedge clk);
         end
         avm_rdata_valid = 1'b0;
         chk("rd_latency", 32'(got_t), 32'(exp_t));
         chk("rd_rdata", resp_rdata, exp_rd);
         chk("rd_err", 32'(resp_err), 32'(exp_err));
         @(negedge clk);
      end
      avm_ready = 1'b0;
      chk("resp_one_cycle", 32'(resp_valid), 32'd0);
      chk("ready_after_resp", 32'(req_ready), 32'd1);
      $display("txn %s addr=%h wdata=%h be=%h bp=%0d p1=%0d p2=%0d -> rdata=%h err=%0d",
               wr ? "WR" : "RD", addr, wdata, be, bp, p1, p2, resp_rdata, resp_err);
   endtask

   // A data strobe while idle: clears a pending stale flag, otherwise ignored.
   task automatic idle_pulse(input logic [31:0] data);
      avm_rdata_valid = 1'b1;
      avm_rdata       = data;
      @(negedge clk);
      avm_rdata_valid = 1'b0;
      m_stale = 1'b0;
      chk("idle_pulse_no_resp", 32'(resp_valid), 32'd0);
      chk("idle_pulse_ready", 32'(req_ready), 32'd1);
      $display("idle rdata_valid data=%h", data);
   endtask

   initial begin
      int acc;
      int nresp;
      int nwr;
      bit bad;
      bit wr;
      int bp;
      int p1;
      int p2;

      // Reset values
      #12;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_cmds", {28'd0, avm_burstbegin, avm_read_req, avm_write_req, 1'b0}, 32'd0);
      chk("rst_addr", 32'(avm_addr), 32'd0);
      chk("rst_wdata", avm_wdata, 32'd0);
      chk("rst_be", 32'(avm_be), 32'd0);
      chk("rst_size", 32'(avm_size), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ready_before_edge", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("ready_after_edge", 32'(req_ready), 32'd1);

      // Directed test-plan steps
      run_txn(1'b1, 32'h0000_0100, 32'hCAFE_F00D, 4'hF, 0, -1, 32'h0, -1, 32'h0);
      run_txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 5, 3, 32'h1234_5678, -1, 32'h0);
      run_txn(1'b0, 32'h0000_0200, 32'h0, 4'hF, 1, -1, 32'h0, -1, 32'h0);
      run_txn(1'b0, 32'h0000_0204, 32'h0, 4'hF, 0, 1, 32'hAAAA_AAAA, 3, 32'h5555_5555);
      run_txn(1'b0, 32'h0000_0300, 32'h0, 4'hF, 2, TMO - 1, 32'h0BAD_CAFE, -1, 32'h0);
      run_txn(1'b0, 32'h0000_0304, 32'h0, 4'hF, 0, 2, 32'h600D_D00D, -1, 32'h0);
      run_txn(1'b0, 32'h0000_0400, 32'h0, 4'hF, 0, -1, 32'h0, -1, 32'h0);
      idle_pulse(32'hDEAD_BEEF);
      run_txn(1'b0, 32'h0000_0404, 32'h0, 4'hF, 0, 0, 32'h1357_9BDF, -1, 32'h0);
      idle_pulse(32'hFEED_FACE);
      run_txn(1'b1, 32'h0000_0408, 32'h0102_0304, 4'h5, 3, -1, 32'h0, -1, 32'h0);

      // Reset in the middle of a back-pressured write
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h0000_0800;
      req_wdata = 32'h7777_8888;
      req_be    = 4'h3;
      avm_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      chk("mid_cmd_write_req", 32'(avm_write_req), 32'd1);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_write_req", 32'(avm_write_req), 32'd0);
      chk("async_rst_burstbegin", 32'(avm_burstbegin), 32'd0);
      chk("async_rst_req_ready", 32'(req_ready), 32'd0);
      chk("async_rst_addr", 32'(avm_addr), 32'd0);
      m_stale = 1'b0;
      @(negedge clk);
      avm_ready = 1'b1;
      rst_n = 1'b1;
      #1;
      chk("rel_ready_before_edge", 32'(req_ready), 32'd0);
      nresp = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (resp_valid === 1'b1) nresp++;
      end
      chk("rst_no_resp", 32'(nresp), 32'd0);
      chk("rel_ready_after_edge", 32'(req_ready), 32'd1);
      avm_ready = 1'b0;
      $display("reset mid-command write: commands dropped, responses=%0d", nresp);

      // Back-to-back writes with req_valid held high
      acc   = 0;
      nresp = 0;
      nwr   = 0;
      bad   = 1'b0;
      req_write = 1'b1;
      avm_ready = 1'b1;
      for (int cyc = 0; cyc < 24; cyc++) begin
         if (resp_valid === 1'b1) nresp++;
         if (avm_write_req === 1'b1) begin
            chk("b2b_wdata", avm_wdata, 32'h1000 + 32'(nwr));
            nwr++;
         end
         if (avm_read_req !== 1'b0 || avm_size !== 1'b1) bad = 1'b1;
         if (acc < 3) begin
            req_valid = 1'b1;
            req_addr  = 32'(acc) << 2;
            req_wdata = 32'h1000 + 32'(acc);
            req_be    = 4'hF;
            if (req_ready === 1'b1) acc++;
         end else begin
            req_valid = 1'b0;
         end
         @(negedge clk);
      end
      avm_ready = 1'b0;
      chk("b2b_accepts", 32'(acc), 32'd3);
      chk("b2b_writes", 32'(nwr), 32'd3);
      chk("b2b_responses", 32'(nresp), 32'd3);
      chk("b2b_no_read_size1", 32'(bad), 32'd0);
      $display("back-to-back: accepts=%0d writes=%0d responses=%0d", acc, nwr, nresp);

      // Random transactions
      for (int n = 0; n < 24; n++) begin
         wr = 1'($urandom % 2);
         bp = int'($urandom_range(0, 3));
         case ($urandom % 4)
            0: begin
               p1 = -1;
               p2 = -1;
            end
            1: begin
               p1 = int'($urandom_range(0, TMO - 1));
               p2 = -1;
            end
            default: begin
               p1 = int'($urandom_range(0, TMO - 3));
               p2 = p1 + int'($urandom_range(1, 2));
            end
         endcase
         run_txn(wr, $urandom, $urandom, 4'($urandom), bp, p1, $urandom, p2, $urandom);
         if ($urandom % 5 == 0) idle_pulse($urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
